// File: rtl/l23_encap_buffer.sv
// ---------------------------------------------------------------------------
// l23_encap_buffer
//   Store-and-forward AXI-Stream frame buffer. Complete frames are collected
//   in a FIFO, a programmable header from the mgmt header RAM is prepended on
//   output, and frames flagged bad (tuser on tlast) or too large for the FIFO
//   are discarded. Sits between the ingress parser and tx.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   L23mgmt_refvalue         header length in bytes, 0 = no header
//   L23mgmt_data/writeaddr/we header RAM write port
//   L23mgmt_run              1 = new frames may start on input and output
//   L23mgmt_idle             run low and both sides at a frame boundary
//   L23mgmt_dropcnt          discarded frames, saturating
//   L23mgmt_framecnt         frames fully sent, wrapping
//   L23i_*                   input stream (tuser sampled with tlast only)
//   L23o_*                   output stream
// ---------------------------------------------------------------------------
module l23_encap_buffer #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 11,
    parameter int HDR_AW  = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_AW-1:0] L23mgmt_refvalue,
    input  logic [DATA_W-1:0] L23mgmt_data,
    input  logic [HDR_AW-1:0] L23mgmt_writeaddr,
    input  logic              L23mgmt_we,
    input  logic              L23mgmt_run,
    output logic              L23mgmt_idle,
    output logic [CNT_W-1:0]  L23mgmt_dropcnt,
    output logic [CNT_W-1:0]  L23mgmt_framecnt,
    input  logic [DATA_W-1:0] L23i_tdata,
    input  logic              L23i_tlast,
    input  logic              L23i_tuser,
    input  logic              L23i_tvalid,
    output logic              L23i_tready,
    output logic [DATA_W-1:0] L23o_tdata,
    output logic              L23o_tlast,
    output logic              L23o_tvalid,
    input  logic              L23o_tready
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int HDR_DEPTH  = 1 << HDR_AW;

    typedef enum logic       {IN_RECV, IN_DISCARD} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_HDR, OUT_PAYLOAD} out_state_t;

    in_state_t          r_in_state;
    out_state_t         r_out_state;
    logic [FIFO_AW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic               r_active;
    logic [DATA_W:0]    r_fifo [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_hdr_ram [HDR_DEPTH];
    logic [HDR_AW-1:0]  r_hdr_len, r_hdr_idx;
    logic [CNT_W-1:0]   r_dropcnt, r_framecnt;
    logic               r_idle, r_otvalid, r_otlast;
    logic [DATA_W-1:0]  r_otdata;

    logic [FIFO_AW-1:0] w_wr_inc, w_rd_inc;
    logic               w_full, w_nofit, w_in_bound, w_in_rdy, w_in_hs;
    logic               w_fifo_we, w_drop, w_o_hs, w_hdr_last;
    logic [HDR_AW-1:0]  w_hdr_rd_idx;
    logic [DATA_W-1:0]  w_hdr_rd;
    logic [DATA_W:0]    w_fifo_rd;

    // ---------------- input side ----------------
    assign w_wr_inc   = r_wr_ptr + 1'b1;
    assign w_full     = (w_wr_inc == r_rd_ptr);
    // The partial frame already owns every free slot: it can never fit.
    assign w_nofit    = w_full && (r_commit_ptr == r_rd_ptr);
    assign w_in_bound = (r_in_state == IN_RECV) && (r_wr_ptr == r_commit_ptr);
    // r_active holds tready low while in reset and on the first cycle after.
    // In the no-fit case the byte is still accepted (and dropped) so the
    // sender never sees a stall on the way into DISCARD.
    assign w_in_rdy   = r_active &&
                        ((r_in_state == IN_DISCARD) ||
                         (!(w_in_bound && !L23mgmt_run) && (!w_full || w_nofit)));
    assign w_in_hs    = w_in_rdy && L23i_tvalid;
    assign w_fifo_we  = w_in_hs && (r_in_state == IN_RECV) && !w_nofit;
    assign w_drop     = w_in_hs && L23i_tlast &&
                        ((r_in_state == IN_DISCARD) || w_nofit || L23i_tuser);

    always_ff @(posedge clk) begin
        if (w_fifo_we) r_fifo[r_wr_ptr] <= {L23i_tlast, L23i_tdata};
    end

    always_ff @(posedge clk) begin
        if (L23mgmt_we) r_hdr_ram[L23mgmt_writeaddr] <= L23mgmt_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_state   <= IN_RECV;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_active     <= 1'b0;
            r_dropcnt    <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_drop) begin
                // rewind over the bad/oversize frame
                r_wr_ptr   <= r_commit_ptr;
                r_in_state <= IN_RECV;
                if (r_dropcnt != '1) r_dropcnt <= r_dropcnt + 1'b1;
            end else if (w_in_hs && (r_in_state == IN_RECV)) begin
                if (w_nofit) begin
                    r_in_state <= IN_DISCARD;
                end else begin
                    r_wr_ptr <= w_wr_inc;
                    if (L23i_tlast) r_commit_ptr <= w_wr_inc;
                end
            end
        end
    end

    // ---------------- output side ----------------
    // Output registers are loaded one byte ahead from async-read storage so
    // a byte is presented every cycle, including the header->payload step.
    // rd_ptr advances as a byte moves into the output register.
    assign w_rd_inc     = r_rd_ptr + 1'b1;
    assign w_fifo_rd    = r_fifo[r_rd_ptr];
    assign w_hdr_rd_idx = (r_out_state == OUT_HDR) ? r_hdr_idx + 1'b1 : '0;
    assign w_hdr_rd     = r_hdr_ram[w_hdr_rd_idx];
    assign w_o_hs       = r_otvalid && L23o_tready;
    assign w_hdr_last   = (r_hdr_idx == r_hdr_len - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_state <= OUT_IDLE;
            r_rd_ptr    <= '0;
            r_hdr_len   <= '0;
            r_hdr_idx   <= '0;
            r_otvalid   <= 1'b0;
            r_otdata    <= '0;
            r_otlast    <= 1'b0;
            r_framecnt  <= '0;
            r_idle      <= 1'b1;
        end else begin
            r_idle <= !L23mgmt_run && w_in_bound && (r_out_state == OUT_IDLE);
            case (r_out_state)
                OUT_IDLE: begin
                    if (L23mgmt_run && (r_commit_ptr != r_rd_ptr)) begin
                        r_hdr_len <= L23mgmt_refvalue;
                        r_otvalid <= 1'b1;
                        if (L23mgmt_refvalue != '0) begin
                            r_hdr_idx   <= '0;
                            r_otdata    <= w_hdr_rd;
                            r_otlast    <= 1'b0;
                            r_out_state <= OUT_HDR;
                        end else begin
                            {r_otlast, r_otdata} <= w_fifo_rd;
                            r_rd_ptr    <= w_rd_inc;
                            r_out_state <= OUT_PAYLOAD;
                        end
                    end
                end
                OUT_HDR: begin
                    if (w_o_hs) begin
                        if (w_hdr_last) begin
                            {r_otlast, r_otdata} <= w_fifo_rd;
                            r_rd_ptr    <= w_rd_inc;
                            r_out_state <= OUT_PAYLOAD;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 1'b1;
                            r_otdata  <= w_hdr_rd;
                        end
                    end
                end
                OUT_PAYLOAD: begin
                    if (w_o_hs) begin
                        if (r_otlast) begin
                            r_otvalid   <= 1'b0;
                            r_framecnt  <= r_framecnt + 1'b1;
                            r_out_state <= OUT_IDLE;
                        end else begin
                            {r_otlast, r_otdata} <= w_fifo_rd;
                            r_rd_ptr <= w_rd_inc;
                        end
                    end
                end
                default: r_out_state <= OUT_IDLE;
            endcase
        end
    end

    assign L23i_tready      = w_in_rdy;
    assign L23o_tvalid      = r_otvalid;
    assign L23o_tdata       = r_otdata;
    assign L23o_tlast       = r_otlast;
    assign L23mgmt_idle     = r_idle;
    assign L23mgmt_dropcnt  = r_dropcnt;
    assign L23mgmt_framecnt = r_framecnt;

endmodule

// File: tb/tb_l23_encap_buffer.sv
// Testbench for l23_encap_buffer (FIFO_AW=4 so the oversize case is reachable).
module tb_l23_encap_buffer;
    localparam int DW = 8, FAW = 4, HAW = 6, CW = 16;

    logic          clk = 1'b0, rst = 1'b0;
    logic [HAW-1:0] refvalue = '0, waddr = '0;
    logic [DW-1:0]  mdata = '0;
    logic          mwe = 1'b0, run = 1'b0, idle;
    logic [CW-1:0] dropcnt, framecnt;
    logic [DW-1:0] i_tdata = '0;
    logic          i_tlast = 1'b0, i_tuser = 1'b0, i_tvalid = 1'b0, i_tready;
    logic [DW-1:0] o_tdata;
    logic          o_tlast, o_tvalid, o_tready = 1'b1;

    always #5 clk = ~clk;

    l23_encap_buffer #(.DATA_W(DW), .FIFO_AW(FAW), .HDR_AW(HAW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .L23mgmt_refvalue(refvalue), .L23mgmt_data(mdata), .L23mgmt_writeaddr(waddr),
        .L23mgmt_we(mwe), .L23mgmt_run(run), .L23mgmt_idle(idle),
        .L23mgmt_dropcnt(dropcnt), .L23mgmt_framecnt(framecnt),
        .L23i_tdata(i_tdata), .L23i_tlast(i_tlast), .L23i_tuser(i_tuser),
        .L23i_tvalid(i_tvalid), .L23i_tready(i_tready),
        .L23o_tdata(o_tdata), .L23o_tlast(o_tlast), .L23o_tvalid(o_tvalid),
        .L23o_tready(o_tready)
    );

    int n_tests = 0, n_fail = 0, stab_err = 0, stall_cnt = 0;
    bit rnd_in = 1'b0;
    logic [8:0] out_q[$], exp_q[$];

    // Output collector + stall stability monitor
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        if (!rst) pv = 1'b0;
        else begin
            if (pv && !pr && (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl)) stab_err++;
            if (o_tvalid && o_tready) out_q.push_back({o_tlast, o_tdata});
            pv = o_tvalid; pr = o_tready; pd = o_tdata; pl = o_tlast;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hdr_write(input logic [HAW-1:0] a, input logic [DW-1:0] d);
        waddr = a; mdata = d; mwe = 1'b1;
        tick(1);
        mwe = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n, input bit last, input bit user);
        int w;
        for (int i = 0; i < n; i++) begin
            while (rnd_in && $urandom_range(0, 1) == 1) begin i_tvalid = 1'b0; tick(1); end
            i_tvalid = 1'b1;
            i_tdata  = 8'(first + i);
            i_tlast  = last && (i == n - 1);
            i_tuser  = user && (i == n - 1);
            w = 0;
            @(negedge clk);
            while (!i_tready && w < 2000) begin w++; stall_cnt++; @(negedge clk); end
            if (w >= 2000) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout byte %02h never accepted", i_tdata);
                i_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tuser = 1'b0;
    endtask

    task automatic push_hdr();
        exp_q.push_back({1'b0, 8'h40});
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'hC0});
    endtask

    task automatic push_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 8'(first + i)});
    endtask

    task automatic wait_out(input int n);
        int w = 0;
        while (out_q.size() < n && w < 3000) begin tick(1); w++; end
        tick(5);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_tests++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b exp 0", o_tvalid); end
        n_tests++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got %b exp 0", i_tready); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle); end
        n_tests++; if ({o_tdata, o_tlast} !== 9'h0) begin n_fail++; $display("FAIL rst_data got %h/%b exp 0", o_tdata, o_tlast); end
        n_tests++; if (dropcnt !== 0 || framecnt !== 0) begin n_fail++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", dropcnt, framecnt); end
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b1;
        hdr_write(6'd0, 8'h40); hdr_write(6'd1, 8'h80); hdr_write(6'd2, 8'hC0);
    endtask

    task automatic test_hdr_frame();
        out_q.delete(); exp_q.delete();
        refvalue = 6'd3;
        push_hdr(); push_frame(8'h11, 7);
        send_bytes(8'h11, 7, 1, 0);
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL hdr_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hdr_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (framecnt !== 16'd1) begin n_fail++; $display("FAIL hdr_framecnt got %0d exp 1", framecnt); end
    endtask

    task automatic test_drop_tuser();
        out_q.delete(); exp_q.delete();
        push_hdr(); push_frame(8'h21, 8); push_hdr(); push_frame(8'h41, 9);
        send_bytes(8'h21, 8, 1, 0);
        send_bytes(8'h31, 7, 1, 1);
        send_bytes(8'h41, 9, 1, 0);
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (dropcnt !== 16'd1) begin n_fail++; $display("FAIL drop_dropcnt got %0d exp 1", dropcnt); end
        n_tests++; if (framecnt !== 16'd3) begin n_fail++; $display("FAIL drop_framecnt got %0d exp 3", framecnt); end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        out_q.delete(); exp_q.delete();
        push_hdr(); push_frame(8'h21, 8); push_hdr(); push_frame(8'h41, 9);
        rnd_in = 1'b1;
        fork
            begin
                send_bytes(8'h21, 8, 1, 0);
                send_bytes(8'h31, 7, 1, 1);
                send_bytes(8'h41, 9, 1, 0);
                repeat (20) tick(1);
                done = 1'b1;
            end
            begin
                while (!done) begin tick(1); o_tready = 1'($urandom_range(0, 1)); end
            end
        join
        rnd_in = 1'b0; o_tready = 1'b1;
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd_stable got %0d violations exp 0", stab_err); end
        n_tests++; if (dropcnt !== 16'd2 || framecnt !== 16'd5) begin n_fail++; $display("FAIL rnd_cnt got %0d/%0d exp 2/5", dropcnt, framecnt); end
    endtask

    task automatic test_oversize();
        out_q.delete(); exp_q.delete();
        o_tready = 1'b0; stall_cnt = 0;
        send_bytes(8'h60, 20, 1, 0);
        n_tests++; if (stall_cnt != 0) begin n_fail++; $display("FAIL ovs_tready got %0d stall cycles exp 0", stall_cnt); end
        tick(5);
        n_tests++; if (dropcnt !== 16'd3) begin n_fail++; $display("FAIL ovs_dropcnt got %0d exp 3", dropcnt); end
        n_tests++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL ovs_tvalid got %b exp 0", o_tvalid); end
        push_hdr(); push_frame(8'h51, 5);
        send_bytes(8'h51, 5, 1, 0);
        tick(3);
        o_tready = 1'b1;
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovs_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovs_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (framecnt !== 16'd6) begin n_fail++; $display("FAIL ovs_framecnt got %0d exp 6", framecnt); end
    endtask

    task automatic test_run_stop();
        out_q.delete(); exp_q.delete();
        refvalue = 6'd0; o_tready = 1'b0;
        push_frame(8'h71, 4);
        send_bytes(8'h71, 4, 1, 0);
        tick(3);
        send_bytes(8'h81, 2, 0, 0);
        run = 1'b0;
        send_bytes(8'h83, 2, 1, 0);
        @(negedge clk);
        n_tests++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL run_tready got %b exp 0", i_tready); end
        n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL run_idle_busy got %b exp 0", idle); end
        tick(1);
        o_tready = 1'b1;
        tick(20);
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL run_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL run_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (idle !== 1'b1 || o_tvalid !== 1'b0) begin n_fail++; $display("FAIL run_idle got idle=%b tvalid=%b exp 1/0", idle, o_tvalid); end
        push_frame(8'h81, 4);
        run = 1'b1;
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL run2_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 4; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL run2_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (framecnt !== 16'd8) begin n_fail++; $display("FAIL run_framecnt got %0d exp 8", framecnt); end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        refvalue = 6'd3; o_tready = 1'b0;
        send_bytes(8'h91, 3, 1, 0);
        while (!o_tvalid && w < 100) begin @(negedge clk); w++; end
        n_tests++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_start got tvalid=%b exp 1", o_tvalid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (o_tvalid !== 1'b0 || i_tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst got tvalid=%b tready=%b exp 0/0", o_tvalid, i_tready); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle got %b exp 1", idle); end
        tick(2);
        rst = 1'b1;
        out_q.delete(); exp_q.delete();
        tick(1);
        n_tests++; if (dropcnt !== 0 || framecnt !== 0) begin n_fail++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", dropcnt, framecnt); end
        o_tready = 1'b1;
        push_hdr(); push_frame(8'hA1, 3);
        send_bytes(8'hA1, 3, 1, 0);
        wait_out(exp_q.size());
        n_tests++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_len got %0d exp %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_byte[%0d] got %h exp %h", i, (i < out_q.size()) ? out_q[i] : 9'h0, exp_q[i]); end
        end
        n_tests++; if (framecnt !== 16'd1) begin n_fail++; $display("FAIL mid_framecnt got %0d exp 1", framecnt); end
    endtask

    initial begin
        test_reset();
        test_hdr_frame();
        test_drop_tuser();
        test_random();
        test_oversize();
        test_run_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end
endmodule
